qadd_arbiter: RTL and testbench
===============================

QADD_ARBITER -- requirements
Module: qadd_arbiter

Interface
REQ-001: Parameter N, default 32, total word width (1 sign bit + N-1 magnitude bits).
REQ-002: Parameter Q, default 15, fractional bits; informational only, no effect on arithmetic.
REQ-003: Parameter NREQ, default 4, number of requesters (2..8).
REQ-004: clk  input  1  single clock; all state updates on rising edge.
REQ-005: rst_n  input  1  asynchronous, active-low reset.
REQ-006: req_valid  input  NREQ  per-requester operation request.
REQ-007: req_ready  output  NREQ  per-requester accept; one-hot or zero.
REQ-008: req_a  input  NREQ*N  operand A; requester i occupies bits [i*N +: N].
REQ-009: req_b  input  NREQ*N  operand B; same packing as req_a.
REQ-010: sat_en  input  1  saturate on magnitude overflow; sampled at request handshake.
REQ-011: rsp_valid  output  1  result available.
REQ-012: rsp_ready  input  1  consumer accepts result.
REQ-013: rsp_id  output  clog2(NREQ)  index of the requester owning the result.
REQ-014: rsp_c  output  N  sign-magnitude sum.
REQ-015: rsp_ovf  output  1  magnitude overflow occurred.
REQ-016: busy  output  1  high in any state other than IDLE.

Function
REQ-017: FSM states are IDLE, EXEC and RESP; exactly one operation is in flight at any time.
REQ-018: In IDLE, req_ready SHALL be asserted combinationally for the round-robin winner only, i.e. the first asserted req_valid searching upward (with wrap) from index ptr; in EXEC and RESP, req_ready SHALL be all zero.
REQ-019: A handshake (req_valid[i] & req_ready[i]) at a clock edge SHALL latch A, B, sat_en and id=i, set ptr=(i+1) mod NREQ, and move to EXEC; ptr SHALL change only on a handshake.
REQ-020: EXEC SHALL last one cycle; at its closing edge rsp_c, rsp_ovf and rsp_id are registered and the FSM moves to RESP with rsp_valid=1.
REQ-021: Latency: rsp_valid SHALL rise 2 cycles after the request handshake edge; throughput is at most one operation per 3 cycles.
REQ-022: In RESP, rsp_valid, rsp_id, rsp_c and rsp_ovf SHALL remain stable until rsp_ready=1; on that edge the FSM moves to IDLE and rsp_valid falls.
REQ-023: Arithmetic (sign-magnitude) for equal signs: magnitude = |A|+|B| truncated to N-1 bits; sign = sign of A, including a zero magnitude (-0 + -0 = -0).
REQ-024: Arithmetic for differing signs: magnitude = larger minus smaller; sign = sign of the larger-magnitude operand; equal magnitudes SHALL give +0 (all zeros).
REQ-025: rsp_ovf SHALL be 1 iff the signs are equal and the magnitude sum carries out of bit N-2; it is never set for differing signs.
REQ-026: On overflow with latched sat_en=1, the magnitude SHALL be all ones (sign unchanged); with sat_en=0, the truncated magnitude is returned.
REQ-027: A requester deasserting req_valid before its handshake SHALL not be granted; arbitration is re-evaluated every IDLE cycle.
REQ-028: Requesters SHALL hold req_valid and operands stable until the handshake; the block does not check this.

Reset
REQ-029: rst_n low SHALL immediately force: state=IDLE, ptr=0, rsp_valid=0, rsp_id=0, rsp_c=0, rsp_ovf=0, busy=0, and latched operands=0.
REQ-030: Reset asserted during EXEC or RESP SHALL discard the in-flight operation with no response issued.
REQ-031: After rst_n rises, requester 0 SHALL have the highest priority on the first arbitration.

Verification
REQ-032: req_valid[0]=1, A=0x00008000, B=0x00004000 -> handshake at edge T; at T+2, rsp_valid=1, rsp_id=0, rsp_c=0x0000C000, rsp_ovf=0.
REQ-033: A=0x00008000, B=0x80008000 -> rsp_c=0x00000000; A=0x80004000, B=0x00008000 -> rsp_c=0x00004000; A=0x80000000, B=0x80000000 -> rsp_c=0x80000000.
REQ-034: A=0x7FFFFFFF, B=0x00000001: with sat_en=0 -> rsp_c=0x00000000, rsp_ovf=1; with sat_en=1 -> rsp_c=0x7FFFFFFF, rsp_ovf=1.
REQ-035: All four req_valid held high from reset, rsp_ready=1 -> grant order 0,1,2,3,0, one grant every 3 cycles.
REQ-036: rsp_ready held low 5 cycles in RESP -> rsp_* stable, req_ready=0, busy=1; release -> IDLE on the next edge.
REQ-037: rst_n pulsed low during EXEC -> outputs zero immediately, no rsp_valid; the next grant goes to the lowest asserted index.

Source files
------------

// File: rtl/qadd_arbiter.sv
// Round-robin arbiter in front of a single sign-magnitude Q-format adder.
// One operation in flight: IDLE grants, EXEC computes, RESP holds the result.
module qadd_arbiter #(
  parameter int N    = 32,
  parameter int Q    = 15,
  parameter int NREQ = 4,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*N-1:0]   req_a,
  input  logic [NREQ*N-1:0]   req_b,
  input  logic                sat_en,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [N-1:0]        rsp_c,
  output logic                rsp_ovf,
  output logic                busy,
  output logic [1:0]          dbg_state
);

  // Handshakes: a transfer happens on a rising clk edge where valid and ready
  // are both high; req_ready never depends on anything but req_valid and state,
  // and rsp_valid/rsp_* are held unchanged until the edge that sees rsp_ready.

  if (NREQ < 2 || NREQ > 8 || Q >= N) begin : g_bad_params
    $error("qadd_arbiter: NREQ must be 2..8 and Q must be below N");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  id_q;
  logic [N-1:0]    a_q, b_q;
  logic            sat_q;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  win_id;
  logic            found;
  logic [IDW:0]    idx;
  logic            hs;

  // Search upward from ptr with wrap; first asserted request wins.
  always_comb begin
    grant  = '0;
    win_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = {1'b0, ptr} + (IDW+1)'(k);
      if (idx >= (IDW+1)'(NREQ)) idx = idx - (IDW+1)'(NREQ);
      if (!found && req_valid[idx[IDW-1:0]]) begin
        found               = 1'b1;
        grant[idx[IDW-1:0]] = 1'b1;
        win_id              = idx[IDW-1:0];
      end
    end
  end

  assign hs        = (state_q == IDLE) && found;
  assign req_ready = (state_q == IDLE) ? grant : '0;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic            sa, sb;
  logic [N-2:0]    ma, mb;
  logic [N-1:0]    msum;
  logic [N-2:0]    mag;
  logic            sign, ovf;

  assign sa = a_q[N-1];
  assign sb = b_q[N-1];
  assign ma = a_q[N-2:0];
  assign mb = b_q[N-2:0];

  // Sign-magnitude add; a magnitude tie with differing signs yields +0.
  always_comb begin
    msum = {1'b0, ma} + {1'b0, mb};
    sign = 1'b0;
    mag  = '0;
    ovf  = 1'b0;
    if (sa == sb) begin
      sign = sa;
      ovf  = msum[N-1];
      mag  = (msum[N-1] && sat_q) ? '1 : msum[N-2:0];
    end else if (ma > mb) begin
      sign = sa;
      mag  = ma - mb;
    end else if (mb > ma) begin
      sign = sb;
      mag  = mb - ma;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      id_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sat_q     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_c     <= '0;
      rsp_ovf   <= 1'b0;
    end else begin
      if (hs) begin
        a_q   <= req_a[win_id*N +: N];
        b_q   <= req_b[win_id*N +: N];
        sat_q <= sat_en;
        id_q  <= win_id;
        ptr   <= (win_id == IDW'(NREQ-1)) ? '0 : win_id + 1'b1;
      end
      if (state_q == EXEC) begin
        rsp_c     <= {sign, mag};
        rsp_ovf   <= ovf;
        rsp_id    <= id_q;
        rsp_valid <= 1'b1;
      end else if (state_q == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_qadd_arbiter.sv
// Self-checking bench for qadd_arbiter: integer reference model, timeline
// model of grants/responses, and a scoreboard monitor on the response port.
module tb_qadd_arbiter;
  localparam int N    = 32;
  localparam int Q    = 15;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int W    = IDW + 1 + N;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a, req_b;
  logic              sat_en;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [N-1:0]      rsp_c;
  logic              rsp_ovf;
  logic              busy;
  logic [1:0]        dbg_state;

  qadd_arbiter #(.N(N), .Q(Q), .NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .sat_en(sat_en), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_c(rsp_c), .rsp_ovf(rsp_ovf),
    .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  int           id_log[$];
  logic [N-1:0] c_log[$];
  logic         ovf_log[$];
  int           rcyc_log[$];

  int m_ptr      = 0;
  bit m_free     = 1'b1;
  int m_rsp_edge = 0;
  int granted    = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [N:0] ref_add(input logic [N-1:0] a, input logic [N-1:0] b, input logic sat);
    longint ma, mb, s, lim;
    logic sign, ovf;
    lim  = longint'(1) << (N-1);
    ma   = longint'(a[N-2:0]);
    mb   = longint'(b[N-2:0]);
    ovf  = 1'b0;
    sign = 1'b0;
    s    = 0;
    if (a[N-1] == b[N-1]) begin
      s    = ma + mb;
      sign = a[N-1];
      if (s >= lim) begin
        ovf = 1'b1;
        s   = sat ? lim - 1 : s - lim;
      end
    end else if (ma > mb) begin
      s = ma - mb; sign = a[N-1];
    end else if (mb > ma) begin
      s = mb - ma; sign = b[N-1];
    end
    return {ovf, sign, s[N-2:0]};
  endfunction

  function automatic int model_winner(input logic [NREQ-1:0] v);
    for (int k = 0; k < NREQ; k++) begin
      int i = (m_ptr + k) % NREQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] rnd_word();
    case ($urandom_range(0, 6))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h0000_0000;
      4:       return {1'b0, 31'($urandom_range(0, 255))};
      default: return $urandom();
    endcase
  endfunction

  // ---------------- driver / timeline model ----------------
  // Checks the request side at the negedge, predicts the grant at the next
  // edge, then returns 1 time unit after that edge.
  task automatic step();
    int w;
    logic [NREQ-1:0] er;
    bit evis;
    @(negedge clk);
    w  = m_free ? model_winner(req_valid) : -1;
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    evis = !m_free && (cyc >= m_rsp_edge);
    check("req_ready", 64'(req_ready), 64'(er));
    check("busy", 64'(busy), 64'(!m_free));
    check("rsp_valid", 64'(rsp_valid), 64'(evis));
    granted = -1;
    if (w >= 0) begin
      exp_q.push_back({IDW'(w), ref_add(req_a[w*N +: N], req_b[w*N +: N], sat_en)});
      m_ptr      = (w + 1) % NREQ;
      m_free     = 1'b0;
      m_rsp_edge = cyc + 2;
      granted    = w;
    end else if (evis && rsp_ready) begin
      m_free = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst_rsp_c", 64'(rsp_c), 64'(0));
    check("rst_rsp_id", 64'(rsp_id), 64'(0));
    check("rst_rsp_ovf", 64'(rsp_ovf), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    exp_q.delete();
    m_free = 1'b1;
    m_ptr  = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_no_rsp", 64'(rsp_valid), 64'(0));
    rst_n = 1'b1;
  endtask

  task automatic drain();
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int t = 0; t < 20 && !m_free; t++) step();
    step();
  endtask

  task automatic run_one(input logic [N-1:0] a, input logic [N-1:0] b, input logic sat,
                         input int rq, input logic [N-1:0] exp_c, input logic exp_ovf);
    req_a[rq*N +: N] = a;
    req_b[rq*N +: N] = b;
    sat_en           = sat;
    req_valid[rq]    = 1'b1;
    rsp_ready        = 1'b1;
    granted          = -1;
    for (int t = 0; t < 20 && granted < 0; t++) step();
    req_valid[rq] = 1'b0;
    for (int t = 0; t < 20 && !m_free; t++) step();
    step();
    if (c_log.size() == 0) begin
      check("directed_no_rsp", 64'(0), 64'(1));
    end else begin
      check("directed_c", 64'(c_log[c_log.size()-1]), 64'(exp_c));
      check("directed_ovf", 64'(ovf_log[ovf_log.size()-1]), 64'(exp_ovf));
      check("directed_id", 64'(id_log[id_log.size()-1]), 64'(rq));
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [N-1:0]   h_c;
  logic [IDW-1:0] h_id;
  logic           h_ovf;
  bit             held = 1'b0;

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst_n) begin
      held = 1'b0;
    end else if (rsp_valid) begin
      if (held) begin
        check("hold_c", 64'(rsp_c), 64'(h_c));
        check("hold_id", 64'(rsp_id), 64'(h_id));
        check("hold_ovf", 64'(rsp_ovf), 64'(h_ovf));
      end
      if (rsp_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("rsp_id", 64'(rsp_id), 64'(e[W-1 -: IDW]));
          check("rsp_ovf", 64'(rsp_ovf), 64'(e[N]));
          check("rsp_c", 64'(rsp_c), 64'(e[N-1:0]));
        end
        id_log.push_back(int'(rsp_id));
        c_log.push_back(rsp_c);
        ovf_log.push_back(rsp_ovf);
        rcyc_log.push_back(cyc);
        held = 1'b0;
      end else begin
        held  = 1'b1;
        h_c   = rsp_c;
        h_id  = rsp_id;
        h_ovf = rsp_ovf;
      end
    end else begin
      held = 1'b0;
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    sat_en    = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    apply_reset();

    // Directed arithmetic vectors
    run_one(32'h0000_8000, 32'h0000_4000, 1'b0, 0, 32'h0000_C000, 1'b0);
    run_one(32'h0000_8000, 32'h8000_8000, 1'b0, 0, 32'h0000_0000, 1'b0);
    run_one(32'h8000_4000, 32'h0000_8000, 1'b0, 0, 32'h0000_4000, 1'b0);
    run_one(32'h8000_0000, 32'h8000_0000, 1'b0, 0, 32'h8000_0000, 1'b0);
    run_one(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0, 32'h0000_0000, 1'b1);
    run_one(32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 0, 32'h7FFF_FFFF, 1'b1);
    run_one(32'hFFFF_FFFF, 32'h8000_0001, 1'b1, 2, 32'hFFFF_FFFF, 1'b1);

    // All requesters held high from reset: order 0,1,2,3,0 every 3 cycles
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*N +: N] = rnd_word();
      req_b[i*N +: N] = rnd_word();
    end
    req_valid = '1;
    rsp_ready = 1'b1;
    apply_reset();
    id_log.delete();
    rcyc_log.delete();
    for (int t = 0; t < 40 && id_log.size() < 5; t++) step();
    if (id_log.size() < 5) begin
      check("rr_timeout", 64'(id_log.size()), 64'(5));
    end else begin
      check("rr_order0", 64'(id_log[0]), 64'(0));
      check("rr_order1", 64'(id_log[1]), 64'(1));
      check("rr_order2", 64'(id_log[2]), 64'(2));
      check("rr_order3", 64'(id_log[3]), 64'(3));
      check("rr_order4", 64'(id_log[4]), 64'(0));
      for (int k = 1; k < 5; k++) check("rr_spacing", 64'(rcyc_log[k] - rcyc_log[k-1]), 64'(3));
    end
    drain();

    // Consumer stalls the response for several cycles
    req_valid = '1;
    rsp_ready = 1'b0;
    granted   = -1;
    for (int t = 0; t < 20 && granted < 0; t++) step();
    for (int t = 0; t < 7; t++) step();
    rsp_ready = 1'b1;
    req_valid = '0;
    step();
    step();

    // Reset during EXEC: grant requester 2, then reset
    drain();
    req_valid    = 4'b0100;
    req_a[2*N +: N] = 32'h0000_1234;
    req_b[2*N +: N] = 32'h0000_0001;
    granted = -1;
    for (int t = 0; t < 20 && granted < 0; t++) step();
    req_valid = 4'b1010;
    apply_reset();
    step();
    check("post_reset_grant", 64'(granted), 64'(1));
    req_valid = '0;
    drain();

    // Randomized traffic
    for (int t = 0; t < 500; t++) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (i == granted) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          req_a[i*N +: N] = rnd_word();
          req_b[i*N +: N] = rnd_word();
        end else if (!req_valid[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            req_a[i*N +: N] = rnd_word();
            req_b[i*N +: N] = rnd_word();
            req_valid[i] = 1'b1;
          end
        end else if ($urandom_range(0, 9) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      sat_en    = 1'($urandom_range(0, 1));
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    drain();
    check("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
